data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 13 +
 rtl/data_mem_array.sv | 35 +++
 rtl/data_mem_responder.sv | 131 +++++++++++++
 tb/tb_data_mem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder.
package data_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port word storage: synchronous write, synchronous read into a held output register.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic              re,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: loads only on a completing read, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Request/ready data memory responder with fixed read and write latencies.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 256,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_mem_read,
  input  logic              data_mem_write,
  input  logic [31:0]       data_mem_address,
  input  logic [31:0]       data_mem_data_write,
  output logic [31:0]       data_mem_read_data,
  output logic              data_mem_ready,
  output logic              data_mem_error
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_M1 = CNT_W'(WRITE_LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [AW-1:0]     cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic              cap_write;

  logic              accept_c;
  logic              req_err_c;
  logic [CNT_W-1:0]  lat_m1_c;
  logic              enter_done_c;
  logic              op_write_c;
  logic              mem_we_c;
  logic              mem_re_c;
  logic [AW-1:0]     mem_addr_c;
  logic [WORD_W-1:0] mem_wdata_c;

  // Request decode and storage port steering for the edge that enters DONE.
  always_comb begin
    accept_c     = 1'b0;
    req_err_c    = 1'b0;
    lat_m1_c     = '0;
    enter_done_c = 1'b0;
    op_write_c   = cap_write;
    mem_addr_c   = cap_addr;
    mem_wdata_c  = cap_wdata;

    req_err_c = (data_mem_read && data_mem_write) ||
                (data_mem_address[1:0] != 2'b00) ||
                (data_mem_address[31:2] >= 30'(DEPTH_WORDS));
    lat_m1_c  = data_mem_write ? WR_M1 : RD_M1;

    if (state == IDLE) begin
      // Single-cycle valid requests complete on the acceptance edge itself.
      accept_c     = data_mem_read || data_mem_write;
      enter_done_c = accept_c && !req_err_c && (lat_m1_c == '0);
      op_write_c   = data_mem_write;
      mem_addr_c   = data_mem_address[AW+1:2];
      mem_wdata_c  = data_mem_data_write;
    end else if (state == BUSY) begin
      enter_done_c = (cnt == CNT_W'(1));
    end

    mem_we_c = enter_done_c && op_write_c && !reset;
    mem_re_c = enter_done_c && !op_write_c && !reset;
  end

  // Control FSM with registered ready/error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      cap_write      <= 1'b0;
      data_mem_ready <= 1'b0;
      data_mem_error <= 1'b0;
    end else begin
      data_mem_ready <= 1'b0;
      data_mem_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            cap_addr  <= data_mem_address[AW+1:2];
            cap_wdata <= data_mem_data_write;
            cap_write <= data_mem_write;
            if (req_err_c) begin
              state          <= DONE;
              data_mem_ready <= 1'b1;
              data_mem_error <= 1'b1;
            end else if (lat_m1_c == '0) begin
              state          <= DONE;
              data_mem_ready <= 1'b1;
            end else begin
              cnt   <= lat_m1_c;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state          <= DONE;
            data_mem_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  data_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .addr  (mem_addr_c),
    .we    (mem_we_c),
    .re    (mem_re_c),
    .wdata (mem_wdata_c),
    .rdata (data_mem_read_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: unit 0 has WRITE_LATENCY=1/READ_LATENCY=2, unit 1 has WRITE_LATENCY=4/READ_LATENCY=3.
module tb_data_mem_responder;

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  rd;
  logic [1:0]  wr;
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic [1:0]  rdy;
  logic [1:0]  err;

  int n_vec;
  int n_bad;

  data_mem_responder #(
    .DEPTH_WORDS(256), .READ_LATENCY(2), .WRITE_LATENCY(1)
  ) u_dut0 (
    .clk                (clk),
    .reset              (rst[0]),
    .data_mem_read      (rd[0]),
    .data_mem_write     (wr[0]),
    .data_mem_address   (addr[0]),
    .data_mem_data_write(wd[0]),
    .data_mem_read_data (rdata[0]),
    .data_mem_ready     (rdy[0]),
    .data_mem_error     (err[0])
  );

  data_mem_responder #(
    .DEPTH_WORDS(256), .READ_LATENCY(3), .WRITE_LATENCY(4)
  ) u_dut1 (
    .clk                (clk),
    .reset              (rst[1]),
    .data_mem_read      (rd[1]),
    .data_mem_write     (wr[1]),
    .data_mem_address   (addr[1]),
    .data_mem_data_write(wd[1]),
    .data_mem_read_data (rdata[1]),
    .data_mem_ready     (rdy[1]),
    .data_mem_error     (err[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on unit u; latency counts edges from the acceptance edge (1) to ready.
  task automatic xact(input int u, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat, input logic exp_err,
                      input logic scram);
    int   n;
    logic got;
    @(negedge clk);
    rd[u] = r; wr[u] = w; addr[u] = a; wd[u] = d;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (rdy[u]) got = 1'b1;
      else if (scram) begin
        rd[u] = ~r; wr[u] = ~w; addr[u] = ~a; wd[u] = ~d;
      end
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("error", 32'(err[u]), 32'(exp_err));
    rd[u] = 1'b0; wr[u] = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", 32'(rdy[u]), 32'd0);
    chk("error_drop", 32'(err[u]), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    clk = 1'b0;
    rst = 2'b11; rd = 2'b00; wr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 32'(rdy[i]), 32'd0);
      chk("reset_error", 32'(err[i]), 32'd0);
      chk("reset_rdata", rdata[i], 32'd0);
    end
    @(negedge clk);
    rst = 2'b00;

    // Unit 0: basic write/read, then error requests.
    xact(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1, 1'b0, 1'b0);
    xact(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         2, 1'b0, 1'b0);
    chk("rd_0x10", rdata[0], 32'hDEAD_BEEF);
    xact(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         1, 1'b1, 1'b0);
    chk("misaligned_keeps_rdata", rdata[0], 32'hDEAD_BEEF);
    xact(0, 1'b0, 1'b1, 32'h0000_0400, 32'h1111_2222, 1, 1'b1, 1'b0);
    chk("range_keeps_rdata", rdata[0], 32'hDEAD_BEEF);
    xact(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         2, 1'b0, 1'b0);
    chk("word0_unchanged", rdata[0], 32'h0BAD_F00D);
    xact(0, 1'b0, 1'b1, 32'h0000_0020, 32'h2020_2020, 1, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         2, 1'b0, 1'b0);
    chk("both_no_write", rdata[0], 32'h2020_2020);
    xact(0, 1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_0255, 1, 1'b0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0,         2, 1'b0, 1'b0);
    chk("last_word", rdata[0], 32'hCAFE_0255);

    // Unit 0: write held through DONE, then a read presented on the first IDLE cycle.
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h40; wd[0] = 32'h0404_0404;
    @(posedge clk); #1;
    chk("held_e1_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    chk("held_e2_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    wr[0] = 1'b0; rd[0] = 1'b1;
    @(posedge clk); #1;
    chk("held_e3_ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rd[0] = 1'b0;
    @(posedge clk); #1;
    chk("held_e4_ready", 32'(rdy[0]), 32'd1);
    chk("held_rdata", rdata[0], 32'h0404_0404);
    @(posedge clk); #1;
    chk("held_e5_ready", 32'(rdy[0]), 32'd0);

    // Unit 1: longer latencies with inputs scrambled while busy.
    xact(1, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4, 1'b0, 1'b1);
    xact(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         3, 1'b0, 1'b1);
    chk("u1_rd_0x10", rdata[1], 32'hDEAD_BEEF);
    repeat (3) @(posedge clk);
    #1;
    chk("u1_rdata_held", rdata[1], 32'hDEAD_BEEF);

    // Unit 1: reset lands on the edge that would have completed the write.
    xact(1, 1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_0008, 4, 1'b0, 1'b0);
    @(negedge clk);
    wr[1] = 1'b1; addr[1] = 32'h8; wd[1] = 32'h1234_5678;
    @(posedge clk); #1;
    chk("rst_e1_ready", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    wr[1] = 1'b0;
    @(posedge clk); #1;
    chk("rst_e2_ready", 32'(rdy[1]), 32'd0);
    @(posedge clk); #1;
    chk("rst_e3_ready", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_e4_ready", 32'(rdy[1]), 32'd0);
    chk("rst_rdata_clear", rdata[1], 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(rdy[1]), 32'd0);
      chk("post_rst_error", 32'(err[1]), 32'd0);
    end
    xact(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 3, 1'b0, 1'b0);
    chk("rst_no_commit", rdata[1], 32'hA5A5_0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
